// File: rtl/led_pattern_gen_if.sv
// LED pattern generator configuration handshake.
// Master requests a mode/duty; slave answers with cfgReady.
interface led_pattern_gen_if #(
   parameter int PWM_WIDTH = 8
);
   logic                 cfgValid;
   logic                 cfgReady;
   logic [1:0]           cfgMode;
   logic [PWM_WIDTH-1:0] cfgDuty;

   modport master (
      output cfgValid,
      output cfgMode,
      output cfgDuty,
      input  cfgReady
   );

   modport slave (
      input  cfgValid,
      input  cfgMode,
      input  cfgDuty,
      output cfgReady
   );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: COUNT / BLINK / SHIFT / PWM on a tick grid.
// Define LED_OUT_REG_EN to register ledGreen and tick (+1 cycle).
module led_pattern_gen #(
   parameter int LED_NUM       = 4,
   parameter int TICK_DIV_LOG2 = 24,
   parameter int PWM_WIDTH     = 8
) (
   input  logic               clk100,
   input  logic               rstN,
   led_pattern_gen_if.slave   cfg,
   output logic [1:0]         curMode,
   output logic               tick,
   output logic [LED_NUM-1:0] ledGreen
);

   typedef enum logic {
      RUN,
      PENDING
   } state_t;

   state_t                   r_state;
   logic                     r_ready;
   logic [1:0]               r_mode;
   logic [1:0]               r_capMode;
   logic [PWM_WIDTH-1:0]     r_duty;
   logic [PWM_WIDTH-1:0]     r_capDuty;
   logic [TICK_DIV_LOG2-1:0] r_presc;
   logic [LED_NUM-1:0]       r_step;
   logic                     r_phase;
   logic [LED_NUM-1:0]       r_onehot;
   logic [PWM_WIDTH-1:0]     r_pwm;

   logic                     w_tick;
   logic                     w_accept;
   logic                     w_apply;
   logic [LED_NUM-1:0]       w_rot;
   logic [LED_NUM-1:0]       w_pat;

   assign w_tick   = &r_presc;
   assign w_accept = cfg.cfgValid && r_ready;
   assign w_apply  = (r_state == PENDING) && w_tick;
   // shift form also covers LED_NUM = 1 (bit 0 stays on)
   assign w_rot    = (r_onehot << 1) | (r_onehot >> (LED_NUM - 1));

   assign cfg.cfgReady = r_ready;
   assign curMode      = r_mode;

   // Config FSM: capture on handshake, apply on the next tick
   always_ff @(posedge clk100 or negedge rstN) begin
      if (!rstN) begin
         r_state   <= RUN;
         r_ready   <= 1'b0;
         r_mode    <= 2'd0;
         r_duty    <= '0;
         r_capMode <= 2'd0;
         r_capDuty <= '0;
      end else begin
         unique case (r_state)
            RUN: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_state   <= PENDING;
                  r_ready   <= 1'b0;
                  r_capMode <= cfg.cfgMode;
                  r_capDuty <= cfg.cfgDuty;
               end
            end
            PENDING: begin
               if (w_tick) begin
                  r_state <= RUN;
                  r_ready <= 1'b1;
                  r_mode  <= r_capMode;
                  r_duty  <= r_capDuty;
               end
            end
            default: begin
               r_state <= RUN;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Free-running prescaler and per-mode pattern state
   always_ff @(posedge clk100 or negedge rstN) begin
      if (!rstN) begin
         r_presc  <= '0;
         r_step   <= '0;
         r_phase  <= 1'b0;
         r_onehot <= LED_NUM'(1);
         r_pwm    <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
         if (w_apply) begin
            r_step   <= '0;
            r_phase  <= 1'b0;
            r_onehot <= LED_NUM'(1);
            r_pwm    <= '0;
         end else begin
            r_pwm <= r_pwm + 1'b1;
            if (w_tick) begin
               r_step   <= r_step + 1'b1;
               r_phase  <= ~r_phase;
               r_onehot <= w_rot;
            end
         end
      end
   end

   // Select the pattern of the applied mode
   always_comb begin
      w_pat = '0;
      unique case (r_mode)
         2'd0: w_pat = r_step;
         2'd1: w_pat = {LED_NUM{r_phase}};
         2'd2: w_pat = r_onehot;
         2'd3: w_pat = {LED_NUM{r_pwm < r_duty}};
         default: w_pat = '0;
      endcase
   end

`ifdef LED_OUT_REG_EN
   logic [LED_NUM-1:0] r_led;
   logic               r_tick;

   // Output register stage for LEDs and tick
   always_ff @(posedge clk100 or negedge rstN) begin
      if (!rstN) begin
         r_led  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_led  <= w_pat;
         r_tick <= w_tick;
      end
   end

   assign ledGreen = r_led;
   assign tick     = r_tick;
`else
   assign ledGreen = w_pat;
   assign tick     = w_tick;
`endif

endmodule
